rr_encoded_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream resource (e.g. an encoder/mux datapath) between N requesters.
- Outputs a registered one-hot grant and its binary-encoded index, so the index can drive the shared datapath's select directly.
- Enforces a maximum hold time per grant, so a stuck requester cannot starve the others.
- Sits between requester blocks and the shared datapath; one instance per shared resource.

---
 rtl/rr_encoded_arbiter_if.sv | 13 +
 rtl/rr_encoded_arbiter.sv | 56 +++++
 tb/tb_rr_encoded_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rr_encoded_arbiter_if.sv
// rr_encoded_arbiter_if: request/grant bus (req in, one-hot gnt, gnt_idx, gnt_valid, timeout pulse) between requesters and arbiter
interface rr_encoded_arbiter_if #(
  parameter int N = 4,
  parameter int W = 2
);
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [W-1:0] gnt_idx;
  logic         gnt_valid;
  logic         timeout;
  modport master(output req, input gnt, gnt_idx, gnt_valid, timeout);
  modport slave(input req, output gnt, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/rr_encoded_arbiter.sv
// rr_encoded_arbiter: round-robin arbiter with max-hold timeout; clk, async active-low rst_n, bus a (req in; gnt, gnt_idx, gnt_valid, timeout out)
module rr_encoded_arbiter #(
  parameter int N        = 4,
  parameter int W        = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_encoded_arbiter_if.slave a
);
  localparam int HW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t         state, state_n;
  logic [W-1:0]   ptr, ptr_n, idx, idx_n, sel;
  logic [HW-1:0]  hc, hc_n;
  logic [N-1:0]   gnt, gnt_n;
  logic           to, to_n, rel, expire, arb, found;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      idx   <= '0;
      hc    <= '0;
      gnt   <= '0;
      to    <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      idx   <= idx_n;
      hc    <= hc_n;
      gnt   <= gnt_n;
      to    <= to_n;
    end
  always_comb begin
    rel    = state == BUSY && !a.req[idx];
    expire = state == BUSY && MAX_HOLD != 0 && hc == HW'(MAX_HOLD) && a.req[idx];
    arb    = state == IDLE || rel || expire;
    ptr_n  = rel || expire ? idx + 1'b1 : ptr;
    found  = 1'b0;
    sel    = '0;
    for (int i = N - 1; i >= 0; i--)
      if (a.req[ptr_n + W'(i)]) begin
        found = 1'b1;
        sel   = ptr_n + W'(i);
      end
    state_n = arb ? (found ? BUSY : IDLE) : state;
    idx_n   = arb ? (found ? sel : '0) : idx;
    gnt_n   = arb ? (found ? N'(1) << sel : '0) : gnt;
    hc_n    = arb ? HW'(found) : (MAX_HOLD == 0 || hc == HW'(MAX_HOLD) ? hc : hc + 1'b1);
    to_n    = expire;
  end
  assign a.gnt       = gnt;
  assign a.gnt_idx   = idx;
  assign a.gnt_valid = |gnt;
  assign a.timeout   = to;
endmodule

// File: tb/tb_rr_encoded_arbiter.sv
// tb_rr_encoded_arbiter: scoreboard bench comparing the arbiter against a behavioural round-robin model
module tb_rr_encoded_arbiter;
  localparam int N  = 4;
  localparam int W  = 2;
  localparam int MH = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  rr_encoded_arbiter_if #(.N(N), .W(W)) bus ();
  rr_encoded_arbiter #(.N(N), .W(W), .MAX_HOLD(MH)) dut (.clk(clk), .rst_n(rst_n), .a(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [N-1:0] gnt;
    logic [W-1:0] idx;
    logic         v;
    logic         to;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int m_g = -1;
  int m_hc = 0;
  int m_ptr = 0;
  bit m_to = 0;
  int held = 0;
  logic [N-1:0] prev = '0;
  logic [N-1:0] r = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int pick(input logic [N-1:0] rq, input int from);
    for (int k = 0; k < N; k++)
      if (rq[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction
  // reference model: advanced on every clock edge, cleared asynchronously by reset
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_g = -1;
      m_hc = 0;
      m_ptr = 0;
      m_to = 0;
    end else begin
      m_to = 0;
      if (m_g < 0) begin
        m_g = pick(bus.req, m_ptr);
        m_hc = 1;
      end else if (!bus.req[m_g] || m_hc == MH) begin
        m_to = bus.req[m_g];
        m_ptr = (m_g + 1) % N;
        m_g = pick(bus.req, m_ptr);
        m_hc = 1;
      end else m_hc++;
    end
    if (clk)
      q.push_back('{gnt: m_g < 0 ? '0 : N'(1) << m_g, idx: m_g < 0 ? '0 : W'(m_g), v: m_g >= 0, to: m_to});
  end
  initial forever begin
    @(negedge clk);
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("gnt", bus.gnt, e.gnt);
      chk("gnt_idx", bus.gnt_idx, e.idx);
      chk("gnt_valid", bus.gnt_valid, e.v);
      chk("timeout", bus.timeout, e.to);
    end
  end
  task automatic hold(input logic [N-1:0] rq, input int n);
    bus.req = rq;
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_gnt", bus.gnt, 0);
    chk("async_idx", bus.gnt_idx, 0);
    chk("async_valid", bus.gnt_valid, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    bus.req = 4'b1111;
    repeat (3) @(negedge clk);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_valid", bus.gnt_valid, 0);
    #1;
    rst_n = 1'b1;
    hold(4'b1111, 2);
    hold(4'b0000, 2);
    hold(4'b0100, 3);
    hold(4'b0000, 3);
    for (int i = 0; i < 24; i++) begin
      held = (bus.gnt != 0 && bus.gnt == prev) ? held + 1 : 1;
      prev = bus.gnt;
      hold(held == 3 ? ~bus.gnt : 4'b1111, 1);
    end
    hold(4'b0000, 2);
    hold(4'b1011, 40);
    hold(4'b0000, 2);
    hold(4'b0010, 20);
    hold(4'b0000, 2);
    hold(4'b0010, 2);
    hold(4'b1100, 2);
    hold(4'b0000, 2);
    hold(4'b1000, 3);
    chk("pre_rst_gnt", bus.gnt, 4'b1000);
    async_reset();
    hold(4'b1000, 3);
    r = '0;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      if ($urandom_range(99) == 0) async_reset();
      hold(r, 1);
    end
    hold(4'b0000, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
